// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared types and constants for the four-channel TDM demultiplexer.
//   NUM_SLOTS : slots per frame
//   SLOT_W    : width of a slot index
//   state_e   : receiver framing state (HUNT / LOCK)
//   slot_t    : slot index type
// -----------------------------------------------------------------------------
package tdm_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_e;

   typedef logic [SLOT_W-1:0] slot_t;

   // True for the slot whose completion closes a frame.
   function automatic logic is_last_slot(input slot_t s);
      return s == slot_t'(NUM_SLOTS - 1);
   endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// -----------------------------------------------------------------------------
// tdm_demux4_if
// Bus between a serial link source and the TDM demultiplexer.
//   din, din_valid, frame_sync : serial input, qualifier and frame marker
//   ch0..ch3                   : last complete word per slot
//   ch_update                  : one-hot 1-cycle pulse per channel write
//   frame_done                 : 1-cycle pulse with ch_update[3]
//   locked                     : receiver is in LOCK
//   sync_err                   : 1-cycle pulse on a framing violation
// Modports: master = link side, slave = demultiplexer.
// -----------------------------------------------------------------------------
interface tdm_demux4_if #(
   parameter int WIDTH = 4
);
   import tdm_pkg::*;

   logic                 din;
   logic                 din_valid;
   logic                 frame_sync;
   logic [WIDTH-1:0]     ch0;
   logic [WIDTH-1:0]     ch1;
   logic [WIDTH-1:0]     ch2;
   logic [WIDTH-1:0]     ch3;
   logic [NUM_SLOTS-1:0] ch_update;
   logic                 frame_done;
   logic                 locked;
   logic                 sync_err;

   modport master (
      output din, din_valid, frame_sync,
      input  ch0, ch1, ch2, ch3, ch_update, frame_done, locked, sync_err
   );

   modport slave (
      input  din, din_valid, frame_sync,
      output ch0, ch1, ch2, ch3, ch_update, frame_done, locked, sync_err
   );

endinterface

// File: rtl/tdm_demux4_demux1to4.sv
// -----------------------------------------------------------------------------
// demux1to4
// Combinational 1-to-4 write-enable decoder, the dual of a 4:1 mux: routes a
// single write strobe to the channel selected by the slot index.
//   slot_i : slot index of the completed word
//   wr_i   : write strobe
//   we_o   : one-hot write enable (all zero when wr_i is low)
// -----------------------------------------------------------------------------
module demux1to4
   import tdm_pkg::*;
(
   input  slot_t                slot_i,
   input  logic                 wr_i,
   output logic [NUM_SLOTS-1:0] we_o
);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      we_o = '0;
      if (wr_i) begin
         case (slot_i)
            2'd0:    we_o = 4'b0001;
            2'd1:    we_o = 4'b0010;
            2'd2:    we_o = 4'b0100;
            default: we_o = 4'b1000;
         endcase
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
// Four-channel time-division demultiplexer. Locks onto the frame marker of a
// serial stream carrying four interleaved WIDTH-bit slots (LSB first),
// deserialises each slot and loads it into one of four channel registers.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : tdm_demux4_if slave (serial input and channel outputs)
// -----------------------------------------------------------------------------
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   tdm_demux4_if.slave       bus
);

   // Bit counter width, and partial register width (kept at least one bit
   // wide so WIDTH=1 still elaborates; it is simply unused then).
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW = (WIDTH > 1) ? WIDTH - 1 : 1;

   typedef logic [CW-1:0] bcnt_t;

   state_e               state_q, state_d;
   bcnt_t                bit_cnt_q, bit_cnt_d;
   slot_t                slot_cnt_q, slot_cnt_d;
   logic [PW-1:0]        partial_q, partial_d;
   logic [WIDTH-1:0]     ch_q [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] ch_update_q;
   logic                 frame_done_q, frame_done_d;
   logic                 sync_err_q, sync_err_d;

   // Bit acceptance: which position/slot the current bit lands in.
   logic                 take;
   bcnt_t                take_pos;
   slot_t                take_slot;

   // Word completion.
   logic                 wr;
   slot_t                wr_slot;
   logic [WIDTH-1:0]     word;
   logic [NUM_SLOTS-1:0] we;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      slot_cnt_d   = slot_cnt_q;
      partial_d    = partial_q;
      sync_err_d   = 1'b0;
      take         = 1'b0;
      take_pos     = '0;
      take_slot    = '0;

      if (bus.din_valid) begin
         case (state_q)
            HUNT: begin
               if (bus.frame_sync) begin
                  state_d = LOCK;
                  take    = 1'b1;
               end
            end
            LOCK: begin
               if (bit_cnt_q == '0 && slot_cnt_q == '0) begin
                  if (bus.frame_sync) begin
                     take = 1'b1;
                  end else begin
                     // Expected frame marker missing: drop the bit and rehunt.
                     state_d    = HUNT;
                     sync_err_d = 1'b1;
                     bit_cnt_d  = '0;
                     slot_cnt_d = '0;
                  end
               end else if (bus.frame_sync) begin
                  // Early marker: abandon the partial slot and restart the
                  // frame on this bit. Written channels stay as they are.
                  sync_err_d = 1'b1;
                  take       = 1'b1;
               end else begin
                  take      = 1'b1;
                  take_pos  = bit_cnt_q;
                  take_slot = slot_cnt_q;
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end

      // Store the accepted bit; the last bit of a slot completes the word.
      wr      = 1'b0;
      wr_slot = take_slot;
      if (take) begin
         if (take_pos == bcnt_t'(WIDTH - 1)) begin
            wr         = 1'b1;
            bit_cnt_d  = '0;
            slot_cnt_d = take_slot + slot_t'(1);
         end else begin
            for (int i = 0; i < PW; i++) begin
               if (take_pos == bcnt_t'(i)) partial_d[i] = bus.din;
            end
            bit_cnt_d  = take_pos + bcnt_t'(1);
            slot_cnt_d = take_slot;
         end
      end

      // Completed word: stored low bits plus the bit arriving now on top.
      word = '0;
      for (int i = 0; i < WIDTH - 1; i++) word[i] = partial_q[i];
      word[WIDTH-1] = bus.din;

      frame_done_d = wr && is_last_slot(wr_slot);
   end

   demux1to4 u_demux (
      .slot_i (wr_slot),
      .wr_i   (wr),
      .we_o   (we)
   );

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= HUNT;
         bit_cnt_q    <= '0;
         slot_cnt_q   <= '0;
         partial_q    <= '0;
         ch_update_q  <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         // NOTE: the channel registers are externally visible and must read 0
         // after reset, so this small register array is reset explicitly
         // rather than treated as an uninitialised memory.
         for (int i = 0; i < NUM_SLOTS; i++) ch_q[i] <= '0;
      end else begin
         // NOTE: all sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         slot_cnt_q   <= slot_cnt_d;
         partial_q    <= partial_d;
         ch_update_q  <= we;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (we[i]) ch_q[i] <= word;
         end
      end
   end

   assign bus.ch0        = ch_q[0];
   assign bus.ch1        = ch_q[1];
   assign bus.ch2        = ch_q[2];
   assign bus.ch3        = ch_q[3];
   assign bus.ch_update  = ch_update_q;
   assign bus.frame_done = frame_done_q;
   assign bus.sync_err   = sync_err_q;
   assign bus.locked     = (state_q == LOCK);

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer. It is the receiving end of the 4:1 selection scheme used on the lab board: a serial bit stream carries four interleaved WIDTH-bit slots per frame. The block locks onto the frame marker, deserialises each slot and routes it into one of four registered channel outputs. It sits between the serial link input and the per-channel display/LED logic.

## Interface
- WIDTH, default 4: bits per slot; legal range 1..8.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- din  in  1  serial data bit, LSB of each slot first.
- din_valid  in  1  qualifies din and frame_sync for this cycle.
- frame_sync  in  1  marks the bit as bit 0 of slot 0; ignored when din_valid=0.
- ch0..ch3  out  WIDTH each  last complete word received for slot 0..3 (registered).
- ch_update  out  4  one-hot, 1-cycle pulse: bit i high the cycle after chi is written.
- frame_done  out  1  1-cycle pulse, coincident with ch_update[3].
- locked  out  1  high while in LOCK state.
- sync_err  out  1  1-cycle pulse on any framing violation.

## Operation
- States:
  - HUNT (reset state).
  - LOCK. Holds bit_cnt (0..WIDTH-1), slot_cnt (0..3) and a WIDTH-1 bit partial shift register.
- Cycles with din_valid=0 change nothing: counters and registers hold, and all pulses deassert.
- HUNT:
  - Bits without frame_sync are discarded.
  - din_valid and frame_sync together: the bit is stored as bit 0 of slot 0, bit_cnt becomes 1 (or the word completes at once if WIDTH=1), slot_cnt=0, and the state moves to LOCK.
- LOCK, valid bit at a position other than slot 0 bit 0:
  - Without frame_sync: the bit is stored at position bit_cnt.
  - If bit_cnt=WIDTH-1, the word {din, partial} is written to ch[slot_cnt] and ch_update[slot_cnt] is set.
  - bit_cnt then wraps to 0 and slot_cnt increments, wrapping 3→0.
- LOCK, valid bit at slot 0 bit 0:
  - Without frame_sync: lost lock. sync_err pulses, the bit is discarded and the state returns to HUNT.
  - With frame_sync: normal; the bit is stored as bit 0.
- LOCK, frame_sync at any other position:
  - Resync: sync_err pulses and the partial slot is discarded.
  - Already-written channel registers are kept.
  - The bit becomes bit 0 of slot 0; the state stays LOCK.
- Slot 3 completion pulses frame_done along with ch_update[3].
- Channel registers change only on word completion. They are never cleared except by reset.
- Reset (any time, including mid-slot):
  - State→HUNT; counters and partial register cleared.
  - ch0..ch3 cleared to 0; ch_update, frame_done, locked and sync_err all 0.

## Timing
- Latency: the final bit of a slot is sampled on edge E. The chi value, ch_update[i] and frame_done are all visible after E and remain for exactly one cycle; chi stays valid afterwards.
- locked rises after the edge that samples the accepted sync bit. It falls after the edge that detects lost lock.
- sync_err is high for one cycle after the offending edge.
- Throughput: one bit per clock when din_valid is held high. A frame is 4·WIDTH valid bits, with no dead cycles between frames.
- Only one ch_update bit is ever high at a time.

## Structure
- Package tdm_pkg:
  - NUM_SLOTS=4.
  - SLOT_W=2.
  - State enum {HUNT, LOCK}.
- Sub-module demux1to4 is a combinational decoder. Inputs: slot_cnt and a write strobe. Output: 4-bit one-hot write enable, which drives the channel register loads and ch_update. It is the dual of the board's 4:1 mux.
- The top level holds the FSM, both counters, the partial shift register and the four channel registers.

## Test plan
All scenarios use WIDTH=4.
- Reset then idle (din_valid=0 for 20 cycles) → all outputs 0, locked=0.
- One frame with slots 0xA, 0x3, 0xF, 0x5, LSB first, frame_sync on bit 0, 16 back-to-back valid bits:
  - ch0=0xA after the 4th edge; ch_update=0001 for one cycle.
  - ch3=0x5 after the 16th edge with frame_done=1.
  - locked=1 throughout.
- The same frame with din_valid=0 inserted every other cycle → identical channel values, each update delayed by the gaps; no sync_err.
- Two frames, the second without frame_sync on its first bit → after frame 1 completes, the next valid bit gives a sync_err pulse, locked=0, and ch0..ch3 keep their frame-1 values.
- frame_sync asserted on bit 2 of slot 1:
  - sync_err pulses and ch1 is unchanged.
  - The next 16 bits form a full frame that updates all four channels.
- reset pulsed asynchronously mid-slot 2 → outputs go to 0 immediately, the state is HUNT, and a subsequent clean frame decodes correctly.
